pe_st_unit: RTL and testbench

PE_ST_UNIT -- requirements
Module: pe_st_unit

---
 rtl/pe_st_unit_if.sv | 42 ++++
 rtl/pe_st_unit.sv | 141 ++++++++++++++
 tb/tb_pe_st_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_st_unit_if.sv
// Bundle of the store-unit streams: stream-length load, address and data inputs,
// and the global/local memory write ports.
interface pe_st_unit_if #(
    parameter int DATA_L            = 32,
    parameter int GLOBAL_MEM_ADDR_L = 16,
    parameter int LOCAL_MEM_ADDR_L  = 10,
    parameter int ST_STREAM_CNT_L   = 8
);
    logic [ST_STREAM_CNT_L-1:0]   st_stream_len;
    logic                         st_stream_len_vld;
    logic [GLOBAL_MEM_ADDR_L-1:0] mem_addr_in;
    logic                         mem_addr_in_req;
    logic                         mem_addr_in_ack;
    logic [DATA_L-1:0]            st_data_in;
    logic                         st_data_in_vld;
    logic                         st_data_in_rdy;
    logic [GLOBAL_MEM_ADDR_L-1:0] global_mem_addr;
    logic [DATA_L-1:0]            global_mem_wr_data;
    logic                         global_mem_wr_req;
    logic                         global_mem_wr_gnt;
    logic [LOCAL_MEM_ADDR_L-1:0]  local_mem_addr;
    logic [DATA_L-1:0]            local_mem_wr_data;
    logic                         local_mem_wr_req;
    logic                         local_mem_wr_gnt;
    logic                         st_busy;

    modport master (
        output st_stream_len, st_stream_len_vld, mem_addr_in, mem_addr_in_req,
               st_data_in, st_data_in_vld, global_mem_wr_gnt, local_mem_wr_gnt,
        input  mem_addr_in_ack, st_data_in_rdy, global_mem_addr, global_mem_wr_data,
               global_mem_wr_req, local_mem_addr, local_mem_wr_data, local_mem_wr_req,
               st_busy
    );

    modport slave (
        input  st_stream_len, st_stream_len_vld, mem_addr_in, mem_addr_in_req,
               st_data_in, st_data_in_vld, global_mem_wr_gnt, local_mem_wr_gnt,
        output mem_addr_in_ack, st_data_in_rdy, global_mem_addr, global_mem_wr_data,
               global_mem_wr_req, local_mem_addr, local_mem_wr_data, local_mem_wr_req,
               st_busy
    );
endinterface

// File: rtl/pe_st_unit.sv
// Store unit: pairs a counted stream of store addresses with store data words and
// issues each pair, in order, as a write to local or global memory.
module pe_st_unit #(
    parameter int DATA_L                = 32,
    parameter int GLOBAL_MEM_ADDR_L     = 16,
    parameter int LOCAL_MEM_ADDR_L      = 10,
    parameter int LOCAL_MEM_INDICATOR_S = 14,
    parameter int LOCAL_MEM_INDICATOR_L = 2,
    parameter logic [LOCAL_MEM_INDICATOR_L-1:0] LOCAL_MEM_INDICATOR = 2'b11,
    parameter int ST_STREAM_CNT_L       = 8,
    parameter int ST_FIFO_DEPTH         = 4
) (
    input logic        clk,
    input logic        rst,
    pe_st_unit_if.slave st
);
    localparam int PTR_W = $clog2(ST_FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(ST_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [ST_STREAM_CNT_L-1:0]   counter_reg, counter_next;
    logic [GLOBAL_MEM_ADDR_L-1:0] addr_mem [ST_FIFO_DEPTH];
    logic [DATA_L-1:0]            data_mem [ST_FIFO_DEPTH];
    logic [PTR_W-1:0]             addr_wr_ptr_reg, addr_rd_ptr_reg;
    logic [PTR_W-1:0]             data_wr_ptr_reg, data_rd_ptr_reg;
    logic [OCC_W-1:0]             addr_occ_reg, addr_occ_next;
    logic [OCC_W-1:0]             data_occ_reg, data_occ_next;
    logic [GLOBAL_MEM_ADDR_L-1:0] head_addr;
    logic [DATA_L-1:0]            head_data;
    logic addr_full, data_full, addr_ack, data_rdy, data_push, pop;
    logic load_accept, pair_vld, head_local;

    // Full flags come from registered occupancy only, so a same-cycle pop never frees a slot early.
    assign addr_full   = (addr_occ_reg == FULL_OCC);
    assign data_full   = (data_occ_reg == FULL_OCC);
    assign load_accept = st.st_stream_len_vld && (counter_reg == '0) && (st.st_stream_len != '0);
    assign addr_ack    = st.mem_addr_in_req && (counter_reg != '0) && !addr_full && !st.st_stream_len_vld;
    assign data_rdy    = rst && !data_full;
    assign data_push   = st.st_data_in_vld && data_rdy;

    assign head_addr  = addr_mem[addr_rd_ptr_reg];
    assign head_data  = data_mem[data_rd_ptr_reg];
    assign pair_vld   = (addr_occ_reg != '0) && (data_occ_reg != '0);
    assign head_local = (head_addr[LOCAL_MEM_INDICATOR_S +: LOCAL_MEM_INDICATOR_L] == LOCAL_MEM_INDICATOR);
    assign pop        = pair_vld && (head_local ? st.local_mem_wr_gnt : st.global_mem_wr_gnt);

    assign st.mem_addr_in_ack    = addr_ack;
    assign st.st_data_in_rdy     = data_rdy;
    assign st.global_mem_addr    = head_addr;
    assign st.global_mem_wr_data = head_data;
    assign st.local_mem_addr     = head_addr[LOCAL_MEM_ADDR_L-1:0];
    assign st.local_mem_wr_data  = head_data;

    always_comb begin
        counter_next = counter_reg;
        if (load_accept)
            counter_next = st.st_stream_len;
        else if (addr_ack)
            counter_next = counter_reg - ST_STREAM_CNT_L'(1);
    end

    always_comb begin
        addr_occ_next = addr_occ_reg;
        if (addr_ack && !pop)
            addr_occ_next = addr_occ_reg + OCC_W'(1);
        else if (!addr_ack && pop)
            addr_occ_next = addr_occ_reg - OCC_W'(1);
        data_occ_next = data_occ_reg;
        if (data_push && !pop)
            data_occ_next = data_occ_reg + OCC_W'(1);
        else if (!data_push && pop)
            data_occ_next = data_occ_reg - OCC_W'(1);
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (addr_ack)
            addr_mem[addr_wr_ptr_reg] <= st.mem_addr_in;
        if (data_push)
            data_mem[data_wr_ptr_reg] <= st.st_data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_reg     <= '0;
            addr_occ_reg    <= '0;
            data_occ_reg    <= '0;
            addr_wr_ptr_reg <= '0;
            addr_rd_ptr_reg <= '0;
            data_wr_ptr_reg <= '0;
            data_rd_ptr_reg <= '0;
        end else begin
            counter_reg  <= counter_next;
            addr_occ_reg <= addr_occ_next;
            data_occ_reg <= data_occ_next;
            if (addr_ack)
                addr_wr_ptr_reg <= addr_wr_ptr_reg + PTR_W'(1);
            if (data_push)
                data_wr_ptr_reg <= data_wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                addr_rd_ptr_reg <= addr_rd_ptr_reg + PTR_W'(1);
                data_rd_ptr_reg <= data_rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (load_accept)
                    state_next = ACTIVE;
            end
            ACTIVE, DRAIN: begin
                if (counter_next != '0)
                    state_next = ACTIVE;
                else if ((addr_occ_next != '0) || (data_occ_next != '0))
                    state_next = DRAIN;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        st.st_busy           = (state_reg != IDLE);
        st.global_mem_wr_req = pair_vld && !head_local;
        st.local_mem_wr_req  = pair_vld && head_local;
    end
endmodule

// File: tb/tb_pe_st_unit.sv
// Directed bench for pe_st_unit: stream counting, FIFO pairing, memory selection,
// grant handling and asynchronous reset.
module tb_pe_st_unit;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic auto_gnt, g_gnt, l_gnt;

    typedef struct {
        logic        is_local;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_q[$];

    pe_st_unit_if bus ();

    pe_st_unit dut (
        .clk (clk),
        .rst (rst),
        .st  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.global_mem_wr_gnt = auto_gnt ? bus.global_mem_wr_req : g_gnt;
        bus.local_mem_wr_gnt  = auto_gnt ? bus.local_mem_wr_req  : l_gnt;
    end

    // Record every granted write, one line per transaction.
    always @(posedge clk) begin
        wr_t w;
        if (bus.global_mem_wr_req && bus.global_mem_wr_gnt) begin
            w.is_local = 1'b0; w.addr = bus.global_mem_addr; w.data = bus.global_mem_wr_data;
            wr_q.push_back(w);
            $display("%0t write global addr=%h data=%h", $time, w.addr, w.data);
        end
        if (bus.local_mem_wr_req && bus.local_mem_wr_gnt) begin
            w.is_local = 1'b1; w.addr = {6'b0, bus.local_mem_addr}; w.data = bus.local_mem_wr_data;
            wr_q.push_back(w);
            $display("%0t write local  addr=%h data=%h", $time, w.addr, w.data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_stream_len = '0; bus.st_stream_len_vld = 1'b0;
        bus.mem_addr_in = '0;   bus.mem_addr_in_req = 1'b0;
        bus.st_data_in = '0;    bus.st_data_in_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; auto_gnt = 1'b0; g_gnt = 1'b0; l_gnt = 1'b0;
        idle_inputs();
        bus.mem_addr_in_req = 1'b1; bus.st_data_in_vld = 1'b1;
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd3;
        repeat (2) cyc();
        @(negedge clk);
        n_total++; if (bus.mem_addr_in_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", bus.mem_addr_in_ack); else n_pass++;
        n_total++; if (bus.st_data_in_rdy !== 1'b0) $display("FAIL rst_rdy: got %b want 0", bus.st_data_in_rdy); else n_pass++;
        n_total++; if ({bus.global_mem_wr_req, bus.local_mem_wr_req} !== 2'b00) $display("FAIL rst_reqs: got %b want 00", {bus.global_mem_wr_req, bus.local_mem_wr_req}); else n_pass++;
        n_total++; if (bus.st_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.st_busy); else n_pass++;
        cyc();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_total++; if (bus.st_data_in_rdy !== 1'b1) $display("FAIL rel_rdy: got %b want 1", bus.st_data_in_rdy); else n_pass++;
        n_total++; if (bus.st_busy !== 1'b0) $display("FAIL rel_busy: got %b want 0", bus.st_busy); else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] addrs [3];
        logic [31:0] datas [3];
        logic        locs  [3];
        int base;
        addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'hC005;
        datas[0] = 32'hAAAA_0001; datas[1] = 32'hBBBB_0002; datas[2] = 32'hCCCC_0003;
        locs[0] = 1'b0; locs[1] = 1'b0; locs[2] = 1'b1;
        auto_gnt = 1'b1;
        base = wr_q.size();
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd3;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.st_stream_len_vld = 1'b0;
            bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = addrs[k];
            bus.st_data_in_vld = 1'b1;  bus.st_data_in = datas[k];
            @(negedge clk);
            n_total++; if (bus.mem_addr_in_ack !== 1'b1) $display("FAIL basic_ack%0d: got %b want 1", k, bus.mem_addr_in_ack); else n_pass++;
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        n_total++; if ({bus.local_mem_wr_req, bus.local_mem_addr} !== {1'b1, 10'h005}) $display("FAIL basic_last_local: got req=%b addr=%h want 1/005", bus.local_mem_wr_req, bus.local_mem_addr); else n_pass++;
        n_total++; if (bus.st_busy !== 1'b1) $display("FAIL basic_busy_before_pop: got %b want 1", bus.st_busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.st_busy !== 1'b0) $display("FAIL basic_busy_after_pop: got %b want 0", bus.st_busy); else n_pass++;
        n_total++;
        if (wr_q.size() != base + 3) $display("FAIL basic_wr_count: got %0d want 3", wr_q.size() - base);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (wr_q[base+i].is_local !== locs[i] || wr_q[base+i].addr !== (locs[i] ? {6'b0, addrs[i][9:0]} : addrs[i]) || wr_q[base+i].data !== datas[i])
                    $display("FAIL basic_wr%0d: got l=%b a=%h d=%h want l=%b a=%h d=%h", i, wr_q[base+i].is_local, wr_q[base+i].addr, wr_q[base+i].data, locs[i], addrs[i], datas[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_len_limit();
        int base, stray;
        auto_gnt = 1'b1;
        base = wr_q.size();
        stray = 0;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd2;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.st_stream_len_vld = 1'b0;
            bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0100 + 16'(k);
            bus.st_data_in_vld = (k < 2); bus.st_data_in = 32'h5000_0000 + 32'(k);
            @(negedge clk);
            n_total++; if (bus.mem_addr_in_ack !== (k < 2)) $display("FAIL len_ack%0d: got %b want %b", k, bus.mem_addr_in_ack, (k < 2)); else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            if (bus.mem_addr_in_ack) stray++;
        end
        n_total++; if (stray != 0) $display("FAIL len_no_extra_ack: got %0d acks want 0", stray); else n_pass++;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd1;
        @(negedge clk);
        n_total++; if (bus.mem_addr_in_ack !== 1'b0) $display("FAIL load_coincide_ack: got %b want 0", bus.mem_addr_in_ack); else n_pass++;
        cyc();
        bus.st_stream_len_vld = 1'b0;
        bus.st_data_in_vld = 1'b1; bus.st_data_in = 32'h5000_0002;
        @(negedge clk);
        n_total++; if (bus.mem_addr_in_ack !== 1'b1) $display("FAIL load_next_ack: got %b want 1", bus.mem_addr_in_ack); else n_pass++;
        cyc();
        idle_inputs();
        repeat (3) cyc();
        @(negedge clk);
        n_total++;
        if (wr_q.size() != base + 3) $display("FAIL len_wr_count: got %0d want 3", wr_q.size() - base);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (wr_q[base+i].is_local !== 1'b0 || wr_q[base+i].addr !== 16'h0100 + 16'(i) || wr_q[base+i].data !== 32'h5000_0000 + 32'(i))
                    $display("FAIL len_wr%0d: got a=%h d=%h want a=%h d=%h", i, wr_q[base+i].addr, wr_q[base+i].data, 16'h0100 + 16'(i), 32'h5000_0000 + 32'(i));
                else n_pass++;
            end
        end
        n_total++; if (bus.st_busy !== 1'b0) $display("FAIL len_busy_end: got %b want 0", bus.st_busy); else n_pass++;
    endtask

    task automatic test_load_ignored();
        int acks, base;
        auto_gnt = 1'b1;
        base = wr_q.size();
        acks = 0;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd3;
        cyc();
        bus.st_stream_len_vld = 1'b0;
        bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0040;
        bus.st_data_in_vld = 1'b1;  bus.st_data_in = 32'h7000_0040;
        @(negedge clk);
        n_total++; if (bus.mem_addr_in_ack !== 1'b1) $display("FAIL ign_first_ack: got %b want 1", bus.mem_addr_in_ack); else n_pass++;
        cyc();
        idle_inputs();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd7;
        for (int k = 1; k < 5; k++) begin
            cyc();
            bus.st_stream_len_vld = 1'b0;
            bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0040 + 16'(k);
            bus.st_data_in_vld = (k < 3); bus.st_data_in = 32'h7000_0040 + 32'(k);
            @(negedge clk);
            if (bus.mem_addr_in_ack) acks++;
        end
        n_total++; if (acks != 2) $display("FAIL ign_remaining_acks: got %0d want 2", acks); else n_pass++;
        cyc();
        idle_inputs();
        repeat (3) cyc();
        @(negedge clk);
        n_total++;
        if (wr_q.size() != base + 3 || wr_q[base+2].addr !== 16'h0042 || wr_q[base+2].data !== 32'h7000_0042)
            $display("FAIL ign_writes: got count %0d want 3 ending 0042/70000042", wr_q.size() - base);
        else n_pass++;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd0;
        cyc();
        bus.st_stream_len_vld = 1'b0; bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0099;
        @(negedge clk);
        n_total++; if ({bus.mem_addr_in_ack, bus.st_busy} !== 2'b00) $display("FAIL zero_len: got ack/busy=%b want 00", {bus.mem_addr_in_ack, bus.st_busy}); else n_pass++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_delayed_gnt();
        logic [31:0] words [5];
        logic [15:0] addrs [4];
        for (int i = 0; i < 5; i++) words[i] = 32'hD000_0000 + 32'(i);
        addrs[0] = 16'h1000; addrs[1] = 16'hC3FF; addrs[2] = 16'h2000; addrs[3] = 16'hC001;
        auto_gnt = 1'b0; g_gnt = 1'b0; l_gnt = 1'b0;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd4;
        for (int k = 0; k < 5; k++) begin
            cyc();
            bus.st_stream_len_vld = 1'b0;
            bus.st_data_in_vld = 1'b1; bus.st_data_in = words[k];
            @(negedge clk);
            n_total++; if (bus.st_data_in_rdy !== (k < 4)) $display("FAIL dly_rdy%0d: got %b want %b", k, bus.st_data_in_rdy, (k < 4)); else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.st_data_in_vld = 1'b0;
            bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = addrs[k];
            @(negedge clk);
            n_total++; if (bus.mem_addr_in_ack !== 1'b1) $display("FAIL dly_ack%0d: got %b want 1", k, bus.mem_addr_in_ack); else n_pass++;
        end
        cyc();
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_total++;
            if ({bus.global_mem_wr_req, bus.local_mem_wr_req} !== 2'b10 || bus.global_mem_addr !== 16'h1000 || bus.global_mem_wr_data !== words[0])
                $display("FAIL dly_hold%0d: got req=%b a=%h d=%h want 10/1000/%h", j, {bus.global_mem_wr_req, bus.local_mem_wr_req}, bus.global_mem_addr, bus.global_mem_wr_data, words[0]);
            else n_pass++;
            cyc();
        end
        g_gnt = 1'b1;
        cyc();
        g_gnt = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus.global_mem_wr_req, bus.local_mem_wr_req} !== 2'b01 || bus.local_mem_addr !== 10'h3FF || bus.local_mem_wr_data !== words[1])
            $display("FAIL dly_second: got req=%b a=%h d=%h want 01/3ff/%h", {bus.global_mem_wr_req, bus.local_mem_wr_req}, bus.local_mem_addr, bus.local_mem_wr_data, words[1]);
        else n_pass++;
    endtask

    task automatic test_gnt_select();
        int base;
        base = wr_q.size();
        cyc();
        g_gnt = 1'b1;
        cyc();
        g_gnt = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.local_mem_wr_req !== 1'b1 || bus.local_mem_addr !== 10'h3FF || wr_q.size() != base)
            $display("FAIL sel_wrong_gnt: got req=%b a=%h writes=%0d want 1/3ff/0", bus.local_mem_wr_req, bus.local_mem_addr, wr_q.size() - base);
        else n_pass++;
        cyc();
        l_gnt = 1'b1;
        cyc();
        l_gnt = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.global_mem_wr_req !== 1'b1 || bus.global_mem_addr !== 16'h2000 || bus.global_mem_wr_data !== 32'hD000_0002)
            $display("FAIL sel_right_gnt: got req=%b a=%h d=%h want 1/2000/d0000002", bus.global_mem_wr_req, bus.global_mem_addr, bus.global_mem_wr_data);
        else n_pass++;
        auto_gnt = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        n_total++;
        if (wr_q.size() != base + 3 || wr_q[base+2].is_local !== 1'b1 || wr_q[base+2].addr !== 16'h0001 || wr_q[base+2].data !== 32'hD000_0003)
            $display("FAIL sel_tail: got count %0d want 3 ending local 0001/d0000003", wr_q.size() - base);
        else n_pass++;
        n_total++; if ({bus.st_busy, bus.st_data_in_rdy} !== 2'b01) $display("FAIL sel_idle: got busy/rdy=%b want 01", {bus.st_busy, bus.st_data_in_rdy}); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int base;
        auto_gnt = 1'b0; g_gnt = 1'b0; l_gnt = 1'b0;
        cyc();
        bus.st_stream_len_vld = 1'b1; bus.st_stream_len = 8'd2;
        for (int k = 0; k < 2; k++) begin
            cyc();
            bus.st_stream_len_vld = 1'b0;
            bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0300 + 16'(k);
            bus.st_data_in_vld = 1'b1;  bus.st_data_in = 32'h9000_0000 + 32'(k);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        n_total++; if (bus.global_mem_wr_req !== 1'b1) $display("FAIL mid_req_before: got %b want 1", bus.global_mem_wr_req); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.global_mem_wr_req, bus.local_mem_wr_req, bus.st_busy, bus.st_data_in_rdy} !== 4'b0000)
            $display("FAIL mid_async_drop: got req/req/busy/rdy=%b want 0000", {bus.global_mem_wr_req, bus.local_mem_wr_req, bus.st_busy, bus.st_data_in_rdy});
        else n_pass++;
        repeat (2) cyc();
        rst = 1'b1;
        auto_gnt = 1'b1;
        base = wr_q.size();
        bus.mem_addr_in_req = 1'b1; bus.mem_addr_in = 16'h0305;
        repeat (4) cyc();
        @(negedge clk);
        n_total++;
        if ({bus.st_busy, bus.mem_addr_in_ack, bus.global_mem_wr_req, bus.st_data_in_rdy} !== 4'b0001 || wr_q.size() != base)
            $display("FAIL mid_after_release: got busy/ack/req/rdy=%b writes=%0d want 0001/0", {bus.st_busy, bus.mem_addr_in_ack, bus.global_mem_wr_req, bus.st_data_in_rdy}, wr_q.size() - base);
        else n_pass++;
        cyc();
        idle_inputs();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_len_limit();
        test_load_ignored();
        test_delayed_gnt();
        test_gnt_select();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
